// File: rtl/reconf_fir_filter.sv
// reconf_fir_filter
//   11-tap direct-form FIR filter with run-time loadable coefficients.
//   One sample is accepted per iEnSample600k strobe. The filter then runs
//   one multiply-accumulate per clock over the delay line and registers the
//   result on oFirOut 12 clocks after the strobe.
//
//   Optional build macro FIR_COEFF_READBACK_EN adds the oRdDtRam readback port.
//
// Ports
//   iClk12M          12 MHz system clock, rising edge
//   iRst             synchronous active-high reset
//   iEnSample600k    one-clock sample strobe
//   iCoeffUpdateFlag high = coefficient load mode (filtering frozen)
//   iCsnRam          coefficient port chip select, active-low
//   iWrnRam          coefficient port write enable, active-low
//   iAddrRam         coefficient address (0..NTAP-1 valid)
//   iWtDtRam         coefficient write data, low CW bits used
//   iFirIn           signed input sample
//   oFirOut          signed filter output, registered
//   oRdDtRam         sign-extended coefficient readback (FIR_COEFF_READBACK_EN only)

module reconf_fir_filter #(
    parameter int NTAP = 11,
    parameter int CW   = 9,
    parameter int DW   = 3,
    parameter int OW   = 16,
    parameter int AW   = 6
) (
    input  logic                 iClk12M,
    input  logic                 iRst,
    input  logic                 iEnSample600k,
    input  logic                 iCoeffUpdateFlag,
    input  logic                 iCsnRam,
    input  logic                 iWrnRam,
    input  logic [AW-1:0]        iAddrRam,
    input  logic [15:0]          iWtDtRam,
    input  logic signed [DW-1:0] iFirIn,
    output logic signed [OW-1:0] oFirOut
`ifdef FIR_COEFF_READBACK_EN
    ,
    output logic [15:0]          oRdDtRam
`endif
);

    // IW must be able to hold NTAP itself: tapIdx==NTAP is the output phase.
    localparam int IW = $clog2(NTAP + 1);
    localparam int PW = DW + CW;

    logic signed [DW-1:0] xLine [NTAP];
    logic signed [CW-1:0] coeff [NTAP];
    logic signed [OW-1:0] acc;
    logic [IW-1:0]        tapIdx;
    logic                 busy;

    logic                 addrValid;
    logic [IW-1:0]        addrIdx;
    logic                 coeffWrite;
    logic [IW-1:0]        macIdx;
    logic signed [PW-1:0] xExt;
    logic signed [PW-1:0] cExt;
    logic signed [PW-1:0] prod;
    logic                 unusedWtDt;

    assign addrValid  = (iAddrRam < AW'(NTAP));
    assign addrIdx    = iAddrRam[IW-1:0];
    assign coeffWrite = iCoeffUpdateFlag && !iCsnRam && !iWrnRam && addrValid;

    // Upper data bits carry no coefficient information.
    assign unusedWtDt = ^iWtDtRam[15:CW];

    // Keep the array index in range during the output phase.
    assign macIdx = (tapIdx < IW'(NTAP)) ? tapIdx : '0;
    assign xExt   = PW'(xLine[macIdx]);
    assign cExt   = PW'(coeff[macIdx]);
    assign prod   = xExt * cExt;

    always_ff @(posedge iClk12M) begin
        if (iRst) begin
            for (int k = 0; k < NTAP; k++) begin
                xLine[k] <= '0;
                coeff[k] <= '0;
            end
            acc     <= '0;
            tapIdx  <= '0;
            busy    <= 1'b0;
            oFirOut <= '0;
        end else if (iCoeffUpdateFlag) begin
            // Load mode freezes filtering: strobes dropped, MAC aborted.
            busy   <= 1'b0;
            tapIdx <= '0;
            if (coeffWrite) begin
                coeff[addrIdx] <= iWtDtRam[CW-1:0];
            end
        end else if (iEnSample600k) begin
            // A strobe while busy restarts the MAC on the new delay line.
            for (int k = NTAP - 1; k > 0; k--) begin
                xLine[k] <= xLine[k-1];
            end
            xLine[0] <= iFirIn;
            acc      <= '0;
            tapIdx   <= '0;
            busy     <= 1'b1;
        end else if (busy) begin
            if (tapIdx == IW'(NTAP)) begin
                oFirOut <= acc;
                busy    <= 1'b0;
                tapIdx  <= '0;
            end else begin
                acc    <= acc + OW'(prod);
                tapIdx <= tapIdx + 1'b1;
            end
        end
    end

`ifdef FIR_COEFF_READBACK_EN
    always_ff @(posedge iClk12M) begin
        if (iRst) begin
            oRdDtRam <= '0;
        end else if (!iCsnRam && iWrnRam) begin
            oRdDtRam <= addrValid ? 16'(coeff[addrIdx]) : 16'h0000;
        end
    end
`endif

endmodule

// File: tb/tb_reconf_fir_filter.sv
// Scoreboard bench for reconf_fir_filter: stimulus pushes expected values
// tagged with the cycle they are due; a negedge monitor pops and compares.

module tb_reconf_fir_filter;

    logic        iClk12M = 1'b0;
    logic        iRst;
    logic        iEnSample600k;
    logic        iCoeffUpdateFlag;
    logic        iCsnRam;
    logic        iWrnRam;
    logic [5:0]  iAddrRam;
    logic [15:0] iWtDtRam;
    logic [2:0]  iFirIn;
    logic [15:0] oFirOut;
`ifdef FIR_COEFF_READBACK_EN
    logic [15:0] oRdDtRam;
`endif

    reconf_fir_filter dut (
        .iClk12M          (iClk12M),
        .iRst             (iRst),
        .iEnSample600k    (iEnSample600k),
        .iCoeffUpdateFlag (iCoeffUpdateFlag),
        .iCsnRam          (iCsnRam),
        .iWrnRam          (iWrnRam),
        .iAddrRam         (iAddrRam),
        .iWtDtRam         (iWtDtRam),
        .iFirIn           (iFirIn),
        .oFirOut          (oFirOut)
`ifdef FIR_COEFF_READBACK_EN
        ,
        .oRdDtRam         (oRdDtRam)
`endif
    );

    always #41 iClk12M = ~iClk12M;

    int cyc = 0;
    always @(posedge iClk12M) cyc <= cyc + 1;

    int          dueQ [$];
    logic [15:0] expQ [$];
    string       nameQ [$];
    bit          selQ [$];

    int testsRun    = 0;
    int testsFailed = 0;

    int          tbH [11];
    int          tbX [11];
    logic [15:0] lastOut;

    // Monitor
    int          mDue;
    logic [15:0] mExp;
    logic [15:0] mAct;
    string       mName;
    bit          mSel;

    always @(negedge iClk12M) begin
        while (dueQ.size() > 0 && dueQ[0] <= cyc) begin
            mDue  = dueQ.pop_front();
            mExp  = expQ.pop_front();
            mName = nameQ.pop_front();
            mSel  = selQ.pop_front();
`ifdef FIR_COEFF_READBACK_EN
            mAct = mSel ? oRdDtRam : oFirOut;
`else
            mAct = oFirOut;
`endif
            testsRun++;
            if (mDue != cyc || mAct !== mExp) begin
                testsFailed++;
                $display("FAIL %s cyc=%0d due=%0d got=0x%04h expected=0x%04h",
                         mName, cyc, mDue, mAct, mExp);
            end
        end
    end

    task automatic tick();
        @(posedge iClk12M);
        #1;
    endtask

    task automatic pushChk(input int due, input logic [15:0] e, input string nm, input bit sel);
        dueQ.push_back(due);
        expQ.push_back(e);
        nameQ.push_back(nm);
        selQ.push_back(sel);
    endtask

    function automatic logic [15:0] modelY();
        int s = 0;
        for (int k = 0; k < 11; k++) s += tbH[k] * tbX[k];
        return 16'(s);
    endfunction

    task automatic modelShift(input logic [2:0] s);
        logic signed [2:0] ss = s;
        for (int k = 10; k > 0; k--) tbX[k] = tbX[k-1];
        tbX[0] = int'(ss);
    endtask

    // One strobe with 20-clock spacing. Normal mode: expect output 13 ticks
    // from now (sampled next edge + 12). Load mode: expect oFirOut held.
    task automatic strobe(input logic [2:0] s, input bit useHand,
                          input logic [15:0] hand, input string nm);
        logic [15:0] e;
        iFirIn        = s;
        iEnSample600k = 1'b1;
        if (!iCoeffUpdateFlag) begin
            modelShift(s);
            e = useHand ? hand : modelY();
            pushChk(cyc + 13, e, nm, 1'b0);
            lastOut = e;
        end else begin
            for (int i = 1; i <= 20; i++) pushChk(cyc + i, lastOut, nm, 1'b0);
        end
        tick();
        iEnSample600k = 1'b0;
        repeat (19) tick();
    endtask

    task automatic wrCoeff(input int a, input logic [15:0] d);
        logic signed [8:0] c = d[8:0];
        iAddrRam = 6'(a);
        iWtDtRam = d;
        iCsnRam  = 1'b0;
        iWrnRam  = 1'b0;
        if (iCoeffUpdateFlag && a < 11) tbH[a] = int'(c);
        tick();
        iCsnRam = 1'b1;
        iWrnRam = 1'b1;
    endtask

`ifdef FIR_COEFF_READBACK_EN
    task automatic rdCoeff(input int a, input logic [15:0] e, input string nm);
        iAddrRam = 6'(a);
        iCsnRam  = 1'b0;
        iWrnRam  = 1'b1;
        pushChk(cyc + 1, e, nm, 1'b1);
        tick();
        iCsnRam = 1'b1;
        tick();
    endtask
`endif

    logic [15:0] coefTbl [11] = '{16'hFE0C, 16'h0000, 16'h0013, 16'h0017, 16'h0000,
                                  16'h0024, 16'h0030, 16'h0000, 16'h0065, 16'h00CD,
                                  16'h01F3};
    logic [15:0] impTbl  [12] = '{16'h000C, 16'h0000, 16'h0013, 16'h0017, 16'h0000,
                                  16'h0024, 16'h0030, 16'h0000, 16'h0065, 16'h00CD,
                                  16'hFFF3, 16'h0000};

    task automatic impulseRun(input string nm);
        for (int i = 0; i < 11; i++) strobe(3'b000, 1'b0, 16'h0, "flush");
        strobe(3'b001, 1'b1, impTbl[0], nm);
        for (int i = 1; i < 12; i++) strobe(3'b000, 1'b1, impTbl[i], nm);
    endtask

    initial begin
        iRst = 1'b1; iEnSample600k = 1'b0; iCoeffUpdateFlag = 1'b0;
        iCsnRam = 1'b1; iWrnRam = 1'b1; iAddrRam = '0; iWtDtRam = '0; iFirIn = '0;
        for (int k = 0; k < 11; k++) begin tbH[k] = 0; tbX[k] = 0; end
        lastOut = 16'h0000;

        tick();
        pushChk(cyc, 16'h0000, "reset_out", 1'b0);
        iRst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) strobe(3'b011, 1'b1, 16'h0000, "zero_coeff");

        iCoeffUpdateFlag = 1'b1;
        for (int a = 0; a < 11; a++) wrCoeff(a, coefTbl[a]);
        iCoeffUpdateFlag = 1'b0;
        tick();

        impulseRun("impulse");

        for (int i = 0; i < 10; i++) strobe(3'b011, 1'b0, 16'h0, "step_pos_ramp");
        strobe(3'b011, 1'b1, 16'h050D, "step_pos");
        strobe(3'b011, 1'b1, 16'h050D, "step_pos");
        for (int i = 0; i < 10; i++) strobe(3'b100, 1'b0, 16'h0, "step_neg_ramp");
        strobe(3'b100, 1'b1, 16'hF944, "step_neg");
        strobe(3'b100, 1'b1, 16'hF944, "step_neg");

        strobe(3'b011, 1'b0, 16'h0, "mixed");
        strobe(3'b111, 1'b0, 16'h0, "mixed");
        strobe(3'b010, 1'b0, 16'h0, "mixed");
        iCoeffUpdateFlag = 1'b1;
        strobe(3'b001, 1'b0, 16'h0, "freeze_hold");
        strobe(3'b011, 1'b0, 16'h0, "freeze_hold");
        iCoeffUpdateFlag = 1'b0;
        strobe(3'b001, 1'b0, 16'h0, "resume");
        strobe(3'b000, 1'b0, 16'h0, "resume");

        wrCoeff(0, 16'h0064);
        iCoeffUpdateFlag = 1'b1;
        wrCoeff(11, 16'h004D);
        wrCoeff(16, 16'h004D);
        wrCoeff(63, 16'h004D);
        iAddrRam = 6'd2; iCsnRam = 1'b0; iWrnRam = 1'b1; iWtDtRam = 16'h0055;
        tick();
        iCsnRam = 1'b1;
        iCoeffUpdateFlag = 1'b0;
        tick();
        impulseRun("impulse_gated");

        // Collision: second strobe 5 clocks after the first.
        iFirIn = 3'b010; iEnSample600k = 1'b1;
        modelShift(3'b010);
        pushChk(cyc + 13, lastOut, "collision_no_first", 1'b0);
        tick();
        iEnSample600k = 1'b0;
        repeat (4) tick();
        iFirIn = 3'b101; iEnSample600k = 1'b1;
        modelShift(3'b101);
        lastOut = modelY();
        pushChk(cyc + 13, lastOut, "collision_out", 1'b0);
        tick();
        iEnSample600k = 1'b0;
        repeat (19) tick();
        strobe(3'b000, 1'b1, 16'h0026, "post_collision");

`ifdef FIR_COEFF_READBACK_EN
        rdCoeff(10, 16'hFFF3, "rd_addr10");
        rdCoeff(20, 16'h0000, "rd_addr20");
        iCoeffUpdateFlag = 1'b1;
        rdCoeff(0, 16'h000C, "rd_addr0_flag");
        iCoeffUpdateFlag = 1'b0;
`endif

        repeat (20) tick();
        if (dueQ.size() != 0) begin
            $display("FAIL scoreboard_drain pending=%0d expected=0", dueQ.size());
            testsFailed += dueQ.size();
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/reconf_fir_filter.md
Name: reconf_fir_filter

Overview:
- 11-tap, reconfigurable, direct-form FIR filter.
- Runs on a 12 MHz system clock and consumes one 3-bit signed sample per 600 kHz sample-enable pulse.
- Coefficients are loaded at run time through a simple SRAM-style write port while a coefficient-update flag is asserted.
- Produces a 16-bit signed output; sits between the ADC-side sample source and downstream DSP.

Parameters:
- NTAP, 11, number of taps and number of valid coefficient addresses (0..NTAP-1).
- CW, 9, coefficient width; signed two's complement, taken from WtDtRam[CW-1:0].
- DW, 3, input sample width; signed.
- OW, 16, output width; signed.
- AW, 6, coefficient address width.

Ports:
- iClk12M  in  1  system clock, 12 MHz; all logic on the rising edge.
- iRst  in  1  reset, synchronous, active-high.
- iEnSample600k  in  1  one-clock sample strobe, nominally every 20 clocks.
- iCoeffUpdateFlag  in  1  high = coefficient load mode.
- iCsnRam  in  1  coefficient port chip select, active-low.
- iWrnRam  in  1  coefficient port write enable, active-low.
- iAddrRam  in  AW  coefficient address.
- iWtDtRam  in  16  coefficient write data.
- iFirIn  in  DW  signed input sample.
- oFirOut  out  OW  signed filter output, registered.

Behaviour:
- Reset (iRst=1 at a clock edge): clears the delay line, all NTAP coefficient registers, the accumulator, the MAC counter/busy flag and oFirOut to 0. Reset has priority over every other input and aborts any computation in progress.
- Coefficient write: at an edge with iCoeffUpdateFlag=1, iCsnRam=0 and iWrnRam=0, coeff[iAddrRam] <= iWtDtRam[CW-1:0].
  - iWtDtRam[15:CW] is ignored.
  - iAddrRam >= NTAP: the write is dropped.
  - Writes with iCoeffUpdateFlag=0 are ignored.
  - Read cycles (iCsnRam=0, iWrnRam=1) have no effect; see the optional feature.
- Update mode (iCoeffUpdateFlag=1):
  - iEnSample600k is ignored, so the delay line is not shifted.
  - Any MAC in progress is aborted.
  - oFirOut holds its value.
- Sample edge (iEnSample600k=1, iCoeffUpdateFlag=0, iRst=0):
  - x[k] <= x[k-1] for k=1..NTAP-1, and x[0] <= iFirIn.
  - Clear the accumulator, set busy, and set tap index=0.
- MAC: on each of the next NTAP clocks, acc += sext(x[idx]) * coeff[idx], then idx++.
  - Uses the signed product DW+CW = 12 bits, accumulated in OW bits. This cannot overflow: max |sum| = 4*256*11 = 11264.
  - y[n] = sum over k=0..10 of h[k]*x[n-k].
- Output: on the clock after the last MAC (sample edge + NTAP+1 = 12 clocks), oFirOut <= acc and busy clears. oFirOut holds between updates.
- A new sample strobe while busy: the new sample is shifted in and the MAC restarts from idx 0; no output is produced for the aborted computation. Nominal 20-clock spacing never triggers this.
- Coefficients and delay line are retained across update-mode entry/exit.

Optional Feature:
- Macro: FIR_COEFF_READBACK_EN.
- With the macro defined:
  - Adds output port oRdDtRam[15:0].
  - At an edge with iCsnRam=0 and iWrnRam=1, oRdDtRam <= sign-extended coeff[iAddrRam], or 0 if iAddrRam >= NTAP.
  - Readback is valid regardless of iCoeffUpdateFlag.
  - oRdDtRam holds otherwise and resets to 0.
- Without the macro: the port is absent and read cycles are no-ops.

Test Plan:
- Reset check: assert iRst for 1 clock → oFirOut = 0x0000. Then strobe 5 samples of 3'b011 with all coefficients 0 → oFirOut stays 0.
- Load and impulse, part 1:
  - Load addr0..10 = 12, 0, 19, 23, 0, 36, 48, 0, 101, 205, 0x1F3 (-13) with the flag high.
  - Drop the flag, apply iFirIn=001 on one strobe, then 000.
  - Each oFirOut, 12 clocks after its strobe, reads 12, 0, 19, 23, 0, 36, 48, 0, 101, 205, 0xFFF3, then 0.
- Step response: with the same coefficients, hold iFirIn=011 → steady oFirOut = 3*431 = 1293 (0x050D). Hold iFirIn=100 → -1724 (0xF944).
- Update-mode freeze and write gating:
  - Raise the flag mid-stream → strobes ignored and oFirOut held; after dropping the flag, filtering resumes from the retained delay line.
  - Writes with the flag low, or to addr 11..63, leave the impulse response unchanged.
- Strobe collision: issue a second strobe 5 clocks after the first → only one output, 12 clocks after the second strobe, computed with both samples in the delay line.
- FIR_COEFF_READBACK_EN: read addr 10 → oRdDtRam = 0xFFF3 one clock later; read addr 20 → 0x0000.
